// File: rtl/alu_registered_if.sv
// Request/response bundle for the registered ALU.
// Request: i_valid, i_a, i_b, i_f. Response: o_valid, o_y and flags.
interface alu_registered_if #(
  parameter int BW_DATA = 32
);
  logic               i_valid;
  logic [BW_DATA-1:0] i_a;
  logic [BW_DATA-1:0] i_b;
  logic [2:0]         i_f;
  logic               o_valid;
  logic [BW_DATA-1:0] o_y;
  logic               o_zero;
  logic               o_carry;
  logic               o_ovf;

  modport master (
    output i_valid, i_a, i_b, i_f,
    input  o_valid, o_y, o_zero,
    input  o_carry, o_ovf
  );

  modport slave (
    input  i_valid, i_a, i_b, i_f,
    output o_valid, o_y, o_zero,
    output o_carry, o_ovf
  );
endinterface

// File: rtl/alu_registered.sv
// Execute-stage ALU with one-cycle registered result and flags.
// Ports: i_clk, i_rstn (async low), bus (slave side of alu_registered_if).
module alu_registered #(
  parameter int BW_DATA = 32
) (
  input logic             i_clk,
  input logic             i_rstn,
  alu_registered_if.slave bus
);
  localparam int MSB = BW_DATA - 1;

  logic [BW_DATA-1:0] bsel;
  logic [BW_DATA:0]   sum;
  logic [BW_DATA-1:0] y_c;
  logic               ovf_c;
  logic               arith;

  // i_f[2] turns the adder into a - b
  assign bsel = bus.i_f[2] ? ~bus.i_b : bus.i_b;
  assign sum  = {1'b0, bus.i_a}
              + {1'b0, bsel}
              + {{BW_DATA{1'b0}}, bus.i_f[2]};
  assign ovf_c = (bus.i_a[MSB] == bsel[MSB])
              && (sum[MSB] != bus.i_a[MSB]);

  always_comb begin
    y_c   = '0;
    arith = 1'b0;
    unique case (bus.i_f)
      3'b000: y_c = bus.i_a & bus.i_b;
      3'b001: y_c = bus.i_a | bus.i_b;
      3'b010: begin
        y_c   = sum[MSB:0];
        arith = 1'b1;
      end
      3'b011: y_c = '0;
      3'b100: y_c = bus.i_a & ~bus.i_b;
      3'b101: y_c = bus.i_a | ~bus.i_b;
      3'b110: begin
        y_c   = sum[MSB:0];
        arith = 1'b1;
      end
      3'b111: begin
        // sign of a-b corrected by overflow
        y_c   = {{(BW_DATA-1){1'b0}},
                 sum[MSB] ^ ovf_c};
        arith = 1'b1;
      end
      default: y_c = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      bus.o_valid <= 1'b0;
      bus.o_y     <= '0;
      bus.o_zero  <= 1'b0;
      bus.o_carry <= 1'b0;
      bus.o_ovf   <= 1'b0;
    end else begin
      bus.o_valid <= bus.i_valid;
      if (bus.i_valid) begin
        bus.o_y     <= y_c;
        bus.o_zero  <= (y_c == '0);
        bus.o_carry <= arith & sum[BW_DATA];
        bus.o_ovf   <= arith & ovf_c;
      end
    end
  end
endmodule

// File: tb/tb_alu_registered.sv
// Scoreboard bench for alu_registered.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_alu_registered;
  logic i_clk;
  logic i_rstn;

  alu_registered_if #(.BW_DATA(32)) bus ();

  alu_registered #(.BW_DATA(32)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] y;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic [2:0]  f);
    exp_t e;
    logic [32:0] w;
    e.y = '0;
    e.c = 1'b0;
    e.v = 1'b0;
    case (f)
      3'd0: e.y = a & b;
      3'd1: e.y = a | b;
      3'd2: begin
        w   = {1'b0, a} + {1'b0, b};
        e.y = w[31:0];
        e.c = w[32];
        e.v = (a[31] == b[31]) && (e.y[31] != a[31]);
      end
      3'd4: e.y = a & ~b;
      3'd5: e.y = a | ~b;
      3'd6: begin
        e.y = a - b;
        e.c = (a >= b);
        e.v = (a[31] != b[31]) && (e.y[31] != a[31]);
      end
      3'd7: begin
        w   = {1'b0, a - b};
        e.y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        e.c = (a >= b);
        e.v = (a[31] != b[31]) && (w[31] != a[31]);
      end
      default: e.y = '0;
    endcase
    e.z = (e.y == 32'd0);
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] y,
                              input logic z,
                              input logic c,
                              input logic v);
    exp_t e;
    e.y = y;
    e.z = z;
    e.c = c;
    e.v = v;
    return e;
  endfunction

  always @(negedge i_clk) begin
    if (bus.o_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("o_y", bus.o_y, e.y);
        chk("o_zero", {31'd0, bus.o_zero}, {31'd0, e.z});
        chk("o_carry", {31'd0, bus.o_carry}, {31'd0, e.c});
        chk("o_ovf", {31'd0, bus.o_ovf}, {31'd0, e.v});
      end
    end
  end

  task automatic issue(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [2:0]  f,
                       input exp_t        e);
    bus.i_valid = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_f     = f;
    q.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    i_rstn      = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_f     = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_y", bus.o_y, 32'd0);
    chk("rst_zero", {31'd0, bus.o_zero}, 32'd0);
    chk("rst_carry", {31'd0, bus.o_carry}, 32'd0);
    chk("rst_ovf", {31'd0, bus.o_ovf}, 32'd0);
    i_rstn = 1'b1;

    // request in flight, then async reset mid-cycle
    issue(32'd5, 32'd3, 3'b001, mk(32'd7, 0, 0, 0));
    #5;
    i_rstn = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("midrst_y", bus.o_y, 32'd0);
    chk("midrst_zero", {31'd0, bus.o_zero}, 32'd0);
    chk("midrst_carry", {31'd0, bus.o_carry}, 32'd0);
    chk("midrst_ovf", {31'd0, bus.o_ovf}, 32'd0);
    bus.i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
    chk("idle_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("idle_y", bus.o_y, 32'd0);

    issue(32'd5, 32'd3, 3'b000, mk(32'd1, 0, 0, 0));
    issue(32'd5, 32'd3, 3'b001, mk(32'd7, 0, 0, 0));
    issue(32'd5, 32'd3, 3'b100, mk(32'd4, 0, 0, 0));
    issue(32'd5, 32'd3, 3'b101,
          mk(32'hFFFF_FFFD, 0, 0, 0));
    issue(32'hFFFF_FFFF, 32'd1, 3'b010,
          mk(32'd0, 1, 1, 0));
    issue(32'hFFFF_FFFF, 32'd1, 3'b110,
          mk(32'hFFFF_FFFE, 0, 1, 0));
    issue(32'h7FFF_FFFF, 32'd1, 3'b010,
          mk(32'h8000_0000, 0, 0, 1));
    issue(32'h8000_0000, 32'd1, 3'b110,
          mk(32'h7FFF_FFFF, 0, 1, 1));
    issue(32'hFFFF_FFFF, 32'd1, 3'b111,
          mk(32'd1, 0, 1, 0));
    issue(32'd1, 32'hFFFF_FFFF, 3'b111,
          mk(32'd0, 1, 0, 0));
    issue(32'h8000_0000, 32'd1, 3'b111,
          mk(32'd1, 0, 1, 1));
    issue(32'd7, 32'd7, 3'b111, mk(32'd0, 1, 1, 0));
    issue(32'd9, 32'd9, 3'b011, mk(32'd0, 1, 0, 0));

    // idle with new operands: result must hold
    bus.i_valid = 1'b0;
    bus.i_a     = 32'd1;
    bus.i_b     = 32'd2;
    bus.i_f     = 3'b010;
    @(posedge i_clk);
    #1;
    chk("hold_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("hold_y", bus.o_y, 32'd0);
    chk("hold_zero", {31'd0, bus.o_zero}, 32'd1);

    a = 32'hFFFF_FFF0;
    b = 32'h7FFF_FFC0;
    for (int i = 0; i < 100; i++) begin
      f = 3'($urandom_range(7));
      issue(a, b, f, model(a, b, f));
      a = a + 32'd1;
      b = b + 32'd2;
    end

    bus.i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_registered.md
Name: alu_registered

Overview:
- Parameterised integer ALU: two BW_DATA-bit operands and a 3-bit function code.
- Produces a registered result plus status flags, one clock after a valid request.
- Used as the execute-stage ALU of a simple MIPS-style datapath (AND/OR/ADD/SUB/SLT plus inverted-B logic ops).
- Single clock domain; asynchronous active-low reset.

Parameters:
- BW_DATA, 32, operand/result width in bits (legal range: 2 or more).

Ports:
- i_clk  input  1  rising-edge clock.
- i_rstn  input  1  asynchronous active-low reset.
- i_valid  input  1  request strobe; operands and function are sampled on the i_clk edge where it is 1.
- i_a  input  BW_DATA  operand A.
- i_b  input  BW_DATA  operand B.
- i_f  input  3  function select.
- o_valid  output  1  result valid, one cycle after an accepted request.
- o_y  output  BW_DATA  registered result.
- o_zero  output  1  1 when the registered o_y equals 0.
- o_carry  output  1  carry-out of the adder path; for SUB/SLT this is the no-borrow bit.
- o_ovf  output  1  signed overflow of the adder path.

Behaviour:
- Reset (i_rstn=0, asynchronous): o_valid=0, o_y=0, o_zero=0, o_carry=0, o_ovf=0. Takes effect immediately and overrides everything, including an in-flight request; that request is dropped.
- Adder path: bsel = i_f[2] ? ~i_b : i_b; sum = i_a + bsel + i_f[2], computed BW_DATA+1 wide.
  - carry = sum[BW_DATA].
  - ovf = (i_a[MSB] == bsel[MSB]) && (sum[MSB] != i_a[MSB]).
- Function codes:
  - 000 AND: a & b.
  - 001 OR: a | b.
  - 010 ADD: a + b, mod 2^BW_DATA.
  - 011 reserved: result 0, carry 0, ovf 0.
  - 100 AND-NOT: a & ~b.
  - 101 OR-NOT: a | ~b.
  - 110 SUB: a - b, mod 2^BW_DATA.
  - 111 SLT (signed): result = {0..., (sum[MSB] ^ ovf)}, i.e. 1 when a < b as two's complement.
- Flag rules:
  - o_carry and o_ovf report the adder path for codes 010, 110 and 111.
  - For the logic codes and 011 they are 0.
  - o_zero is computed from the selected result.
- Timing:
  - Combinational result is computed from i_a/i_b/i_f.
  - On a rising i_clk edge with i_valid=1: o_y and the flags load; o_valid is set to 1.
  - On a rising edge with i_valid=0: o_y and the flags hold their previous values; o_valid is set to 0.
  - Latency is exactly 1 cycle. Throughput is one request per cycle; back-to-back requests are allowed.
- Inputs may change every cycle; only the values present at a qualifying edge matter.
- There is no backpressure; the consumer must capture the result whenever o_valid=1.

Test Plan:
- Reset: assert i_rstn=0 mid-cycle while i_valid=1 -> all outputs 0 immediately. Release, then apply an idle cycle -> o_valid stays 0.
- Logic ops, a=5, b=3, i_f swept 000,001,100,101 on consecutive valid cycles:
  - o_y = 1, 7, 4, 0xFFFFFFFD, each one cycle later.
  - o_valid=1 on each of those cycles; carry=0, ovf=0.
- Arithmetic, a=0xFFFFFFFF, b=1:
  - ADD -> o_y=0, zero=1, carry=1, ovf=0.
  - SUB -> o_y=0xFFFFFFFE, carry=1, ovf=0.
- Overflow:
  - a=0x7FFFFFFF, b=1, ADD -> o_y=0x80000000, ovf=1.
  - a=0x80000000, b=1, SUB -> o_y=0x7FFFFFFF, ovf=1.
- SLT:
  - a=0xFFFFFFFF (-1), b=1 -> o_y=1.
  - a=1, b=0xFFFFFFFF -> o_y=0.
  - a=0x80000000, b=1 -> o_y=1 (overflow-corrected).
  - a=b=7 -> o_y=0.
- Reserved and hold:
  - i_f=011, a=9, b=9 -> o_y=0, zero=1.
  - Next cycle i_valid=0 with new operands -> o_y unchanged, o_valid=0.
  - Random i_f over 100 incrementing (a+=1, b+=2) operand pairs -> every result matches the reference model.
